// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
//  Shared types for the instruction fetch unit: address/instruction word
//  types, FSM state encoding and the default reset PC.
//  Optional feature macro used by this slice: IFU_PERF_CNT_EN.
// ---------------------------------------------------------------------------
package ifu_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] instr_t;

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      HOLD = 2'd1,
      HALT = 2'd2
   } ifu_state_t;

   localparam addr_t IFU_RESET_PC_DEFAULT = '0;

endpackage

// File: rtl/ifu_if.sv
// ---------------------------------------------------------------------------
// ifu_if
//  Bundles the fetch unit's memory, decode, redirect and halt signals.
//   master : fetch unit side (drives imem_addr, instr_*, halted, fetch_count)
//   slave  : environment side (instruction memory, decode, branch unit)
//  fetch_count exists only when IFU_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
interface ifu_if;
   import ifu_pkg::*;

   addr_t  imem_addr;
   instr_t imem_instr;
   logic   instr_valid;
   logic   instr_ready;
   instr_t instr_out;
   addr_t  instr_pc;
   logic   redirect_valid;
   addr_t  redirect_pc;
   logic   halt;
   logic   halted;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   modport master (
      output imem_addr,
      input  imem_instr,
      output instr_valid,
      input  instr_ready,
      output instr_out,
      output instr_pc,
      input  redirect_valid,
      input  redirect_pc,
      input  halt,
      output halted
`ifdef IFU_PERF_CNT_EN
      ,
      output fetch_count
`endif
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      input  instr_valid,
      output instr_ready,
      input  instr_out,
      input  instr_pc,
      output redirect_valid,
      output redirect_pc,
      output halt,
      input  halted
`ifdef IFU_PERF_CNT_EN
      ,
      input  fetch_count
`endif
   );

endinterface

// File: rtl/ifu_pc_reg.sv
// ---------------------------------------------------------------------------
// ifu_pc_reg
//  Program counter register. Load has priority over increment; with neither
//  asserted the PC holds. Increment wraps modulo 2^32.
//  Ports: clk, rst_n (async, active low), load/load_pc, inc, pc (registered).
// ---------------------------------------------------------------------------
module ifu_pc_reg
   import ifu_pkg::*;
#(
   parameter addr_t RESET_PC = IFU_RESET_PC_DEFAULT,
   parameter addr_t PC_STEP  = 32'd1
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load,
   input  addr_t load_pc,
   input  logic  inc,
   output addr_t pc
);

   addr_t pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load)
         pc_d = load_pc;
      else if (inc)
         pc_d = pc_q + PC_STEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//  Fetch stage in front of a fixed-latency instruction memory. Owns the PC,
//  waits MEM_LATENCY edges for the memory word, captures it and offers it to
//  decode with valid/ready. Supports redirects and a sticky halt.
//  Ports: clk, rst_n (async, active low), bus (ifu_if.master).
//  Optional: define IFU_PERF_CNT_EN for the fetch_count handshake counter.
// ---------------------------------------------------------------------------
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter addr_t       RESET_PC    = IFU_RESET_PC_DEFAULT,
   parameter addr_t       PC_STEP     = 32'd1,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic  clk,
   input  logic  rst_n,
   ifu_if.master bus
);

   localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY);

   ifu_state_t  state_q, state_d;
   logic [2:0]  lat_q, lat_d;
   instr_t      instr_q, instr_d;
   addr_t       ipc_q, ipc_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        pc_load, pc_inc;
   addr_t       pc;
   logic        handshake;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;
`endif

   ifu_pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (pc_load),
      .load_pc (bus.redirect_pc),
      .inc     (pc_inc),
      .pc      (pc)
   );

   // valid_q is only ever set while in HOLD
   assign handshake = valid_q & bus.instr_ready;

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      instr_d  = instr_q;
      ipc_d    = ipc_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      pc_load  = 1'b0;
      pc_inc   = 1'b0;
`ifdef IFU_PERF_CNT_EN
      cnt_d    = cnt_q;
      if (state_q != HALT && handshake)
         cnt_d = cnt_q + 32'd1;
`endif
      if (state_q == HALT) begin
         // frozen until reset
      end else if (bus.halt) begin
         // a handshake in the same cycle still retires its instruction;
         // any redirect is ignored
         pc_inc   = handshake;
         state_d  = HALT;
         valid_d  = 1'b0;
         halted_d = 1'b1;
         lat_d    = '0;
      end else begin
         unique case (state_q)
            WAIT: begin
               if (bus.redirect_valid) begin
                  // abandon the in-flight fetch and restart the latency count
                  pc_load = 1'b1;
                  lat_d   = '0;
               end else if (lat_q == LAT_LAST) begin
                  instr_d = bus.imem_instr;
                  ipc_d   = pc;
                  lat_d   = '0;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  lat_d = lat_q + 3'd1;
               end
            end
            HOLD: begin
               if (handshake || bus.redirect_valid) begin
                  // redirect wins over sequential increment
                  pc_load = bus.redirect_valid;
                  pc_inc  = ~bus.redirect_valid;
                  valid_d = 1'b0;
                  state_d = WAIT;
               end
            end
            default: begin
               state_d = HALT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= WAIT;
         lat_q    <= '0;
         instr_q  <= '0;
         ipc_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
`ifdef IFU_PERF_CNT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         instr_q  <= instr_d;
         ipc_q    <= ipc_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
`ifdef IFU_PERF_CNT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.instr_valid = valid_q;
   assign bus.instr_out   = instr_q;
   assign bus.instr_pc    = ipc_q;
   assign bus.halted      = halted_q;
`ifdef IFU_PERF_CNT_EN
   assign bus.fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//  Pairs the fetch unit with a registered instruction memory model
//  (IM[i] = A000_0000 + i) and compares against a delivery-level reference:
//  expected next PC, edges since the last fetch restart, delivered count.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;
   import ifu_pkg::*;

   localparam int MEM_LAT = 1;
   localparam addr_t IM_BASE = 32'hA000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ifu_if bus();

   instruction_fetch_unit #(
      .RESET_PC    (32'h0),
      .PC_STEP     (32'd1),
      .MEM_LATENCY (MEM_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // instruction memory: MEM_LAT registered stages
   instr_t mem_pipe [MEM_LAT];
   always @(posedge clk) begin
      mem_pipe[0] <= IM_BASE + bus.imem_addr;
      for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
   end
   assign bus.imem_instr = mem_pipe[MEM_LAT-1];

   int checks = 0;
   int errors = 0;

   // reference model: next PC to deliver, edges since fetch restart
   addr_t       m_pc;
   int          m_k;
   int unsigned m_cnt;
   bit          m_halted;

   function automatic bit m_valid();
      return !m_halted && (m_k >= MEM_LAT + 1);
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_k = 0; m_cnt = 0; m_halted = 0;
   endtask

   // advance one clock; model follows the inputs the DUT sees at the edge
   task automatic step();
      bit v, hs;
      v = m_valid();
      @(posedge clk);
      hs = v && bus.instr_ready;
      if (!m_halted) begin
         if (hs) m_cnt++;
         if (bus.halt) begin
            if (hs) m_pc = m_pc + 32'd1;
            m_halted = 1; m_k = 0;
         end else if (bus.redirect_valid) begin
            m_pc = bus.redirect_pc; m_k = 0;
         end else if (hs) begin
            m_pc = m_pc + 32'd1; m_k = 0;
         end else if (m_k < 1000) begin
            m_k++;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.halt = 0;
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.halt = 0;
      @(negedge clk);
      rst_n = 0;
      model_reset();
      #1;
      checks += 6;
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
      if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
      if (bus.instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.instr_out); end
      if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_ipc got %h want 0", bus.instr_pc); end
      if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
`ifdef IFU_PERF_CNT_EN
      if (bus.fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fetch_count); end
`else
      if (bus.imem_instr === 32'hx) checks--;
      else checks--;
`endif
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_sequential();
      addr_t got[$];
      int first = -1;
      do_reset();
      bus.instr_ready = 1;
      for (int i = 0; i < 13; i++) begin
         checks += 2;
         if (bus.instr_valid !== m_valid()) begin errors++; $display("FAIL seq_valid edge %0d got %b want %b", i, bus.instr_valid, m_valid()); end
         if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL seq_addr edge %0d got %h want %h", i, bus.imem_addr, m_pc); end
         if (bus.instr_valid === 1'b1) begin
            if (first < 0) first = i;
            got.push_back(bus.instr_pc);
            checks++;
            if (bus.instr_out !== IM_BASE + bus.instr_pc) begin errors++; $display("FAIL seq_instr got %h want %h", bus.instr_out, IM_BASE + bus.instr_pc); end
         end
         step();
      end
      checks += 2;
      if (first != 2) begin errors++; $display("FAIL seq_first_valid_edge got %0d want 2", first); end
      if (got.size() != 4) begin errors++; $display("FAIL seq_count got %0d want 4", got.size()); end
      else for (int j = 0; j < 4; j++) begin
         checks++;
         if (got[j] !== addr_t'(j)) begin errors++; $display("FAIL seq_order idx %0d got %h want %h", j, got[j], j); end
      end
   endtask

   task automatic test_stall();
      instr_t o; addr_t p, a;
      do_reset();
      bus.instr_ready = 0;
      step(); step();
      checks++;
      if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_enter got %b want 1", bus.instr_valid); end
      o = bus.instr_out; p = bus.instr_pc; a = bus.imem_addr;
      for (int i = 0; i < 5; i++) begin
         step();
         checks += 4;
         if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b want 1", i, bus.instr_valid); end
         if (bus.instr_out !== IM_BASE) begin errors++; $display("FAIL stall_instr cyc %0d got %h want %h", i, bus.instr_out, IM_BASE); end
         if (bus.instr_pc !== 32'h0 || bus.instr_pc !== p) begin errors++; $display("FAIL stall_ipc cyc %0d got %h want 0", i, bus.instr_pc); end
         if (bus.imem_addr !== 32'h0 || bus.imem_addr !== a || bus.instr_out !== o) begin errors++; $display("FAIL stall_addr cyc %0d got %h want 0", i, bus.imem_addr); end
      end
      bus.instr_ready = 1;
      step();
      checks += 2;
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b want 0", bus.instr_valid); end
      if (bus.imem_addr !== 32'h1) begin errors++; $display("FAIL stall_release_addr got %h want 1", bus.imem_addr); end
   endtask

   task automatic test_redirect_hold();
      do_reset();
      bus.instr_ready = 0;
      step(); step();
      bus.redirect_valid = 1; bus.redirect_pc = 32'h10;
      step();
      bus.redirect_valid = 0;
      checks += 2;
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rdh_drop got %b want 0", bus.instr_valid); end
      if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL rdh_addr got %h want 10", bus.imem_addr); end
      step(); step();
      checks += 3;
      if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL rdh_valid got %b want 1", bus.instr_valid); end
      if (bus.instr_pc !== 32'h10) begin errors++; $display("FAIL rdh_ipc got %h want 10", bus.instr_pc); end
      if (bus.instr_out !== 32'hA000_0010) begin errors++; $display("FAIL rdh_instr got %h want a0000010", bus.instr_out); end
   endtask

   task automatic test_redirect_handshake();
      int i;
      logic [31:0] c0;
      do_reset();
      bus.instr_ready = 1;
      for (i = 0; i < 40 && !(bus.instr_valid === 1'b1 && bus.instr_pc === 32'h3); i++) step();
      checks++;
      if (i >= 40) begin errors++; $display("FAIL rdhs_reach_pc3 got timeout want instr_pc 3"); end
`ifdef IFU_PERF_CNT_EN
      c0 = bus.fetch_count;
`else
      c0 = 32'(m_cnt);
`endif
      bus.redirect_valid = 1; bus.redirect_pc = 32'h40;
      step();
      bus.redirect_valid = 0;
      checks += 2;
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rdhs_valid got %b want 0", bus.instr_valid); end
      if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rdhs_addr got %h want 40", bus.imem_addr); end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (bus.fetch_count !== c0 + 32'd1) begin errors++; $display("FAIL rdhs_count got %0d want %0d", bus.fetch_count, c0 + 32'd1); end
`else
      if (c0 != 32'd3) $display("note: model count %0d", c0);
`endif
      step(); step();
      checks += 3;
      if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL rdhs_next_valid got %b want 1", bus.instr_valid); end
      if (bus.instr_pc !== 32'h40) begin errors++; $display("FAIL rdhs_next_ipc got %h want 40", bus.instr_pc); end
      if (bus.instr_out !== 32'hA000_0040) begin errors++; $display("FAIL rdhs_next_instr got %h want a0000040", bus.instr_out); end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.instr_ready = 0;
      step(); step();
      bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFF;
      step();
      bus.redirect_valid = 0;
      step(); step();
      checks += 2;
      if (bus.instr_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_ipc got %h want ffffffff", bus.instr_pc); end
      if (bus.instr_out !== 32'h9FFF_FFFF) begin errors++; $display("FAIL wrap_instr got %h want 9fffffff", bus.instr_out); end
      bus.instr_ready = 1;
      step();
      checks++;
      if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", bus.imem_addr); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         checks += 2;
         if (bus.instr_valid !== m_valid()) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, bus.instr_valid, m_valid()); end
         if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, bus.imem_addr, m_pc); end
         if (m_valid()) begin
            checks += 2;
            if (bus.instr_pc !== m_pc) begin errors++; $display("FAIL rnd_ipc cyc %0d got %h want %h", i, bus.instr_pc, m_pc); end
            if (bus.instr_out !== IM_BASE + m_pc) begin errors++; $display("FAIL rnd_instr cyc %0d got %h want %h", i, bus.instr_out, IM_BASE + m_pc); end
         end
         bus.instr_ready    = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = ($urandom_range(0, 9) == 0);
         bus.redirect_pc    = $urandom;
         step();
      end
      bus.redirect_valid = 0;
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (bus.fetch_count !== 32'(m_cnt)) begin errors++; $display("FAIL rnd_count got %0d want %0d", bus.fetch_count, m_cnt); end
`endif
   endtask

   task automatic test_halt();
      do_reset();
      bus.instr_ready = 1;
      step(); step(); step();
      // now in WAIT after the first handshake, fetching PC 1
      bus.halt = 1;
      step();
      checks += 3;
      if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", bus.halted); end
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", bus.instr_valid); end
      if (bus.imem_addr !== 32'h1) begin errors++; $display("FAIL halt_addr got %h want 1", bus.imem_addr); end
      for (int i = 0; i < 20; i++) begin
         bus.redirect_valid = ($urandom_range(0, 1) == 1);
         bus.redirect_pc    = $urandom;
         step();
         checks += 3;
         if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_hold_valid cyc %0d got %b want 0", i, bus.instr_valid); end
         if (bus.imem_addr !== 32'h1) begin errors++; $display("FAIL halt_hold_addr cyc %0d got %h want 1", i, bus.imem_addr); end
         if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_hold_flag cyc %0d got %b want 1", i, bus.halted); end
      end
      bus.redirect_valid = 0; bus.halt = 0;
      step();
      checks++;
      if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b want 1", bus.halted); end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (bus.fetch_count !== 32'd1) begin errors++; $display("FAIL halt_count got %0d want 1", bus.fetch_count); end
`endif
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      bus.instr_ready = 1;
      step(); step(); step();
      bus.instr_ready = 0;
      step(); step();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h1) begin errors++; $display("FAIL rmh_setup got valid %b pc %h want 1/1", bus.instr_valid, bus.instr_pc); end
      #2 rst_n = 0;
      #1;
      checks += 4;
      if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rmh_valid got %b want 0", bus.instr_valid); end
      if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rmh_addr got %h want 0", bus.imem_addr); end
      if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rmh_ipc got %h want 0", bus.instr_pc); end
      if (bus.instr_out !== 32'h0) begin errors++; $display("FAIL rmh_instr got %h want 0", bus.instr_out); end
`ifdef IFU_PERF_CNT_EN
      checks++;
      if (bus.fetch_count !== 32'h0) begin errors++; $display("FAIL rmh_count got %0d want 0", bus.fetch_count); end
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1;
      step(); step();
      checks += 2;
      if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL rmh_restart_valid got %b want 1", bus.instr_valid); end
      if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rmh_restart_ipc got %h want 0", bus.instr_pc); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_hold();
      test_redirect_handshake();
      test_wrap();
      test_random();
      test_halt();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
